// File: rtl/elm_pkg.sv
// Shared constants and FSM state encoding for the ELM deserializer
// sequencing controller.
package elm_pkg;
  localparam int WORDS      = 16;
  localparam int WORD_W     = 16;
  localparam int CNT_W      = 5;
  localparam int IDX_W      = 8;
  localparam int TX_TIMEOUT = 15;
  localparam int VEC_W      = WORDS * WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;
endpackage

// File: rtl/elm_deser_ctrl_if.sv
// Upstream word stream, deserializer control lines and downstream vector
// handshake of the ELM deserializer controller.
interface elm_deser_ctrl_if;
  import elm_pkg::*;

  // Handshake rule for both streams: a transfer happens on a rising clk edge
  // where valid and ready are both high; valid is never withdrawn before that.
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  logic [WORD_W-1:0] des_data;
  logic              des_rx;
  logic [CNT_W-1:0]  des_count;
  logic              des_tx;

  logic              vec_valid;
  logic              vec_ready;
  logic              vec_last;
  logic [IDX_W-1:0]  vec_idx;

  modport master (
    input  in_valid, in_data, des_tx, vec_ready,
    output in_ready, des_data, des_rx, des_count, vec_valid, vec_last, vec_idx
  );

  modport slave (
    output in_valid, in_data, des_tx, vec_ready,
    input  in_ready, des_data, des_rx, des_count, vec_valid, vec_last, vec_idx
  );
endinterface

// File: rtl/elm_tx_watchdog.sv
// Loadable down-counter bounding the wait for the deserializer ready pulse;
// expire_o is high in the enabled cycle where the count has run out.
module elm_tx_watchdog #(
  parameter int unsigned LOAD_VAL = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(LOAD_VAL + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Loading LOAD_VAL-1 makes expiry fall in the LOAD_VAL-th enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(LOAD_VAL - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= W'(LOAD_VAL - 1);
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/elm_deser_ctrl.sv
// Sequences 16-bit words into the 256-bit deserializer and hands each
// assembled vector downstream, repeating for batch_len vectors per batch.
module elm_deser_ctrl
  import elm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  batch_len,
  elm_deser_ctrl_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_e            dbg_state_o
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             accept, last_word, vec_hs, wd_expire;

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.des_rx    = accept;
  assign bus.des_data  = bus.in_data;
  assign bus.des_count = cnt_q;
  assign last_word     = accept && (cnt_q == CNT_W'(1));

  assign bus.vec_valid = (state_q == ST_PRESENT);
  assign bus.vec_idx   = idx_q;
  assign bus.vec_last  = (idx_q == len_q - IDX_W'(1));
  assign vec_hs        = bus.vec_valid && bus.vec_ready;

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;
  assign dbg_state_o = state_q;

  elm_tx_watchdog #(.LOAD_VAL(TX_TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (last_word),
    .en_i     (state_q == ST_WAIT_TX),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    err_d   = err_q;
    if (accept) cnt_d = cnt_q - CNT_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = batch_len;
          idx_d   = '0;
          err_d   = 1'b0;
          cnt_d   = CNT_W'(WORDS);
          state_d = (batch_len != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (last_word) state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // A ready pulse coinciding with expiry still wins.
        if (bus.des_tx) begin
          state_d = ST_PRESENT;
        end else if (wd_expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          cnt_d   = CNT_W'(WORDS);
        end
      end
      ST_PRESENT: begin
        if (vec_hs) begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = CNT_W'(WORDS);
          state_d = bus.vec_last ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_W'(WORDS);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_W'(WORDS);
      idx_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_elm_deser_ctrl.sv
// Bench for elm_deser_ctrl with a behavioural deserializer beside the DUT;
// inputs change on negedges, outputs are sampled on negedges.
module tb_elm_deser_ctrl;
  import elm_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [IDX_W-1:0] batch_len = '0;
  logic             busy, done, err;
  state_e           dbg_state;

  elm_deser_ctrl_if bus();

  elm_deser_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .batch_len   (batch_len),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // ---------------- deserializer model ----------------
  // Shifts words in MSB-first and raises tx for one cycle, one edge after
  // the count first reads zero.
  logic             tx_m = 1'b0, tx_fired = 1'b0, tx_kill = 1'b0, tx_inject = 1'b0;
  logic [VEC_W-1:0] par = '0;
  logic [VEC_W-1:0] exp_q[$];

  assign bus.des_tx = (tx_m & ~tx_kill) | tx_inject;

  always @(posedge clk) begin
    if (bus.des_rx === 1'b1) par <= {par[VEC_W-WORD_W-1:0], bus.des_data};
    tx_m     <= (bus.des_count == '0) && !tx_fired;
    tx_fired <= (bus.des_count == '0);
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // ---------------- batch driver + scoreboard ----------------
  // gap_mode: 0 always valid, 1 alternating valid, 2 random valid.
  task automatic run_batch(input int len, input int gap_mode, input int stall_idx,
                           input int stall_n, input bit seq_words, input bit poke);
    int w, k, d0;
    logic [VEC_W-1:0]  exp_v;
    logic [WORD_W-1:0] words[$];
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; batch_len = IDX_W'(len);
    @(negedge clk);
    start = 1'b0; batch_len = IDX_W'($urandom);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_after_start: got %b want 0", err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
    if (len == 0) begin
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_len_done: got %b want 1", done); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_len_in_ready: got %b want 0", bus.in_ready); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_len_end: done %b busy %b want 0 0", done, busy); end
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_len_done_count: got %0d want 1", done_cnt - d0); end
      return;
    end
    for (int v = 0; v < len; v++) begin
      words.delete();
      for (int i = 0; i < WORDS; i++) words.push_back(seq_words ? WORD_W'(i + 1) : WORD_W'($urandom));
      exp_v = '0;
      for (int i = 0; i < WORDS; i++) exp_v[VEC_W-WORD_W*(i+1) +: WORD_W] = words[i];
      exp_q.push_back(exp_v);
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL load_entry v%0d: in_ready %b want 1", v, bus.in_ready); end
      w = 0; k = 0;
      while (w < WORDS && k < 200) begin
        case (gap_mode)
          0:       bus.in_valid = 1'b1;
          1:       bus.in_valid = (k % 2 == 0);
          default: bus.in_valid = 1'($urandom_range(0, 1));
        endcase
        bus.in_data = bus.in_valid ? words[w] : WORD_W'($urandom);
        tx_inject = (gap_mode != 0) && !bus.in_valid && (w == 3);
        #1;
        n_checks++; if (bus.des_count !== CNT_W'(WORDS - w)) begin n_fail++; $display("FAIL des_count v%0d w%0d: got %0d want %0d", v, w, bus.des_count, WORDS - w); end
        n_checks++; if (bus.des_rx !== bus.in_valid) begin n_fail++; $display("FAIL des_rx v%0d w%0d: got %b want %b", v, w, bus.des_rx, bus.in_valid); end
        if (bus.des_rx === 1'b1) begin
          n_checks++; if (bus.des_data !== words[w]) begin n_fail++; $display("FAIL des_data v%0d w%0d: got %h want %h", v, w, bus.des_data, words[w]); end
          w++;
        end
        k++;
        @(negedge clk);
      end
      tx_inject = 1'b0;
      n_checks++; if (w != WORDS) begin n_fail++; $display("FAIL word_accepts v%0d: got %0d want %0d", v, w, WORDS); return; end
      // Upstream stays valid with junk that must not be taken.
      bus.in_valid = 1'b1; bus.in_data = WORD_W'($urandom);
      k = 1;
      while (bus.vec_valid !== 1'b1 && k < 40) begin
        n_checks++; if (bus.in_ready !== 1'b0 || bus.des_rx !== 1'b0) begin n_fail++; $display("FAIL wait_tx_quiet v%0d: in_ready %b des_rx %b want 0 0", v, bus.in_ready, bus.des_rx); end
        @(negedge clk); k++;
      end
      // Visible at the third negedge after the last accept = from edge E0+2.
      n_checks++; if (k != 3) begin n_fail++; $display("FAIL vec_valid_latency v%0d: got %0d want 3", v, k); if (bus.vec_valid !== 1'b1) return; end
      exp_v = exp_q.pop_front();
      n_checks++; if (par !== exp_v) begin n_fail++; $display("FAIL vector_data v%0d: got %h want %h", v, par, exp_v); end
      n_checks++; if (bus.vec_idx !== IDX_W'(v)) begin n_fail++; $display("FAIL vec_idx v%0d: got %0d want %0d", v, bus.vec_idx, v); end
      n_checks++; if (bus.vec_last !== (v == len - 1)) begin n_fail++; $display("FAIL vec_last v%0d: got %b want %b", v, bus.vec_last, (v == len - 1)); end
      if (v == stall_idx) begin
        for (int s = 0; s < stall_n; s++) begin
          bus.vec_ready = 1'b0;
          start = poke && (s == 0); batch_len = IDX_W'($urandom);
          #1;
          n_checks++; if (bus.vec_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.des_rx !== 1'b0) begin n_fail++; $display("FAIL stall v%0d s%0d: valid %b in_ready %b des_rx %b want 1 0 0", v, s, bus.vec_valid, bus.in_ready, bus.des_rx); end
          n_checks++; if (bus.vec_idx !== IDX_W'(v) || bus.vec_last !== (v == len - 1)) begin n_fail++; $display("FAIL stall_stable v%0d: idx %0d last %b", v, bus.vec_idx, bus.vec_last); end
          @(negedge clk);
        end
        start = 1'b0;
      end
      bus.vec_ready = 1'b1;
      @(negedge clk);
      bus.vec_ready = 1'b0;
      if (v != len - 1) begin
        n_checks++; if (bus.vec_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL after_hs v%0d: valid %b done %b want 0 0", v, bus.vec_valid, done); end
      end else begin
        n_checks++; if (done !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL done_pulse: done %b in_ready %b want 1 0", done, bus.in_ready); end
        n_checks++; if (bus.des_count !== CNT_W'(WORDS)) begin n_fail++; $display("FAIL done_count: got %0d want %0d", bus.des_count, WORDS); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL batch_end: done %b busy %b want 0 0", done, busy); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL done_count_batch: got %0d want 1", done_cnt - d0); end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0 || bus.des_rx !== 1'b0 || bus.vec_valid !== 1'b0 || bus.vec_last !== 1'b0) begin n_fail++; $display("FAIL reset_bus: in_ready %b des_rx %b valid %b last %b want 0", bus.in_ready, bus.des_rx, bus.vec_valid, bus.vec_last); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy %b done %b err %b want 0", busy, done, err); end
    n_checks++; if (bus.des_count !== CNT_W'(WORDS) || bus.vec_idx !== '0) begin n_fail++; $display("FAIL reset_regs: count %0d idx %0d want %0d 0", bus.des_count, bus.vec_idx, WORDS); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    run_batch(1, 0, -1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_batch(3, 0, 1, 5, 1'b0, 1'b1);
  endtask

  task automatic test_gaps();
    run_batch(1, 1, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len();
    run_batch(0, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int k, d0;
    d0 = done_cnt;
    tx_kill = 1'b1;
    @(negedge clk); start = 1'b1; batch_len = IDX_W'(1);
    @(negedge clk); start = 1'b0;
    bus.in_valid = 1'b1;
    repeat (WORDS) begin bus.in_data = WORD_W'($urandom); @(negedge clk); end
    k = 1;
    while (busy === 1'b1 && k < 40) begin
      n_checks++; if (bus.vec_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_wait: valid %b in_ready %b want 0 0", bus.vec_valid, bus.in_ready); end
      @(negedge clk); k++;
    end
    tx_kill = 1'b0; bus.in_valid = 1'b0;
    // TX_TIMEOUT cycles in WAIT_TX, then idle at the next negedge.
    n_checks++; if (k != TX_TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", k, TX_TIMEOUT + 1); end
    n_checks++; if (err !== 1'b1 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL timeout_err: err %b state %0d want 1 0", err, dbg_state); end
    n_checks++; if (done_cnt != d0 || bus.des_count !== CNT_W'(WORDS)) begin n_fail++; $display("FAIL timeout_side: dones %0d count %0d want 0 %0d", done_cnt - d0, bus.des_count, WORDS); end
    repeat (3) @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    run_batch(1, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1; batch_len = IDX_W'(2);
    @(negedge clk); start = 1'b0;
    bus.in_valid = 1'b1;
    repeat (7) begin bus.in_data = WORD_W'($urandom); @(negedge clk); end
    n_checks++; if (bus.des_count !== CNT_W'(WORDS - 7)) begin n_fail++; $display("FAIL mid_count: got %0d want %0d", bus.des_count, WORDS - 7); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.des_rx !== 1'b0 || bus.vec_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_reset_out: in_ready %b des_rx %b valid %b busy %b done %b", bus.in_ready, bus.des_rx, bus.vec_valid, busy, done); end
    n_checks++; if (bus.des_count !== CNT_W'(WORDS) || bus.vec_idx !== '0 || err !== 1'b0) begin n_fail++; $display("FAIL async_reset_regs: count %0d idx %0d err %b", bus.des_count, bus.vec_idx, err); end
    @(negedge clk); rst_n = 1'b1; bus.in_valid = 1'b0;
    run_batch(2, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++)
      run_batch($urandom_range(1, 4), 2, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, 1'b1);
  endtask

  // ---------------- main + report ----------------
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.vec_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "global time limit reached");
  end
endmodule

// File: doc/elm_deser_ctrl.md
# elm_deser_ctrl

Sequencing controller for the 256-bit input deserializer of the ELM engine. It accepts 16-bit words from an upstream stream and drives the deserializer's shift strobe, word counter and data lines. It watches the deserializer's one-cycle ready pulse and presents each assembled 256-bit vector to the hidden-layer datapath with a valid/ready handshake, repeating for a programmable number of vectors per inference batch.

## Interface
- WORDS, 16: words per vector.
- WORD_W, 16: word width.
- CNT_W, 5: width of `des_count`; must hold WORDS.
- IDX_W, 8: width of the batch length and vector index.
- TX_TIMEOUT, 15: maximum cycles to wait in WAIT_TX for `des_tx`.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a batch; honoured only in IDLE.
- batch_len  in  IDX_W  vectors in the batch; sampled on an accepted `start`.
- in_valid  in  1  upstream word valid.
- in_data  in  WORD_W  upstream word.
- in_ready  out  1  controller accepts a word this cycle.
- des_data  out  WORD_W  word to deserializer (`serial_data`).
- des_rx  out  1  deserializer shift strobe (`rx`).
- des_count  out  CNT_W  words remaining (`count`).
- des_tx  in  1  deserializer vector-ready pulse (`tx`).
- vec_valid  out  1  assembled vector available downstream.
- vec_ready  in  1  downstream accepts the vector.
- vec_last  out  1  the current vector is the last of the batch.
- vec_idx  out  IDX_W  index of the current vector, starting at 0.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse when the batch completes.
- err  out  1  sticky flag: `des_tx` timeout.

## Operation
- States and transitions:
  - IDLE: `start` with `batch_len`≠0 goes to LOAD. `start` with `batch_len`=0 goes to DONE.
  - LOAD: goes to WAIT_TX when the last word is accepted.
  - WAIT_TX: `des_tx`=1 goes to PRESENT. Timeout goes to IDLE and sets `err`.
  - PRESENT: on the `vec_valid` & `vec_ready` handshake, goes to DONE if `vec_last`, otherwise back to LOAD.
  - DONE: goes to IDLE after one cycle.
- Upstream interface:
  - `in_ready` = (state==LOAD), combinational.
  - `des_rx` = `in_valid` & `in_ready`.
  - `des_data` = `in_data`, combinational pass-through.
- `des_count` is a register:
  - Loaded with WORDS on an accepted `start` and on each PRESENT→LOAD transition.
  - Decrements on every accepted word and reaches 0 exactly when word WORDS is accepted.
  - Held at WORDS in IDLE and DONE, so a non-zero count keeps the deserializer from raising a spurious `tx` while `rx` is low.
- `des_tx` is ignored in every state except WAIT_TX.
- While in PRESENT, `des_rx`=0. The deserializer output is therefore stable until the vector is accepted.
- Vector index and flags:
  - `vec_idx` is cleared on `start` and increments on each vector handshake.
  - `vec_last` = (`vec_idx` == `batch_len`−1).
- `err` is set on timeout and cleared on the next accepted `start`. A timeout does not pulse `done`.
- `start` while `busy` is ignored. A new `batch_len` has no effect mid-batch.

## Timing
- Reset values: state IDLE, `des_count`=WORDS, `vec_idx`=0, `err`=0.
- Output reset values: `in_ready`=0, `des_rx`=0, `vec_valid`=0, `vec_last`=0, `busy`=0, `done`=0.
- Accepted `start` at edge E: `in_ready`=1 from cycle E+1.
- LOAD with upstream always valid: WORDS consecutive accepts with no bubbles.
- Last word accepted at edge E0. The deserializer raises `tx` at E1. The controller samples it at E2. `vec_valid`=1 from E2 onward, i.e. 2 cycles after the last accept.
- Vector handshake at edge E:
  - Not last: `in_ready` is high in cycle E+1.
  - Last: `done`=1 in cycle E+1, IDLE from E+2.
- WAIT_TX timeout: if `des_tx` has not been seen after TX_TIMEOUT cycles, go to IDLE.
- Reset asserted mid-batch: all outputs return to reset values immediately. The deserializer is not reset; its stale state is harmless because `rx`=0 and `count`≠0 are held.
- `vec_valid` is never withdrawn without a handshake. `vec_idx` and `vec_last` are stable while `vec_valid`=1.

## Structure
- Shared package `elm_pkg`: WORDS, WORD_W, CNT_W constants and the state encoding (IDLE, LOAD, WAIT_TX, PRESENT, DONE).
- One sub-module: `elm_tx_watchdog`, a loadable down-counter that pulses on expiry, used for the WAIT_TX timeout.
- The deserializer is instantiated beside this block at the engine top, not inside it.

## Test plan
- Single vector: `batch_len`=1, words 0x0001..0x0010 back-to-back. Required: 16 `des_rx` pulses, `des_count` 16→0, `vec_valid` 2 cycles after the last accept, `parallel_data`=0x0001…0010, `vec_last`=1, `done` one cycle after handshake.
- Batch of 3, with `vec_ready` held low 5 cycles on vector 1. Required: `in_ready`=0 and `des_rx`=0 throughout the stall, `vec_idx` 0,1,2, exactly one `done`.
- Upstream gaps: `in_valid` toggling 1/0 over 16 words. Required: `des_count` decrements only on accepts and `vec_valid` timing is relative to the last accept.
- `batch_len`=0: `start` gives `done` in the next cycle, no `in_ready`, `busy` high for one cycle.
- `des_tx` forced low: timeout after 15 cycles in WAIT_TX. Required: `err`=1, state IDLE, no `done`; the next `start` clears `err`.
- `rst_n` pulsed low at word 7 of vector 0. Required: outputs return to reset values asynchronously, and a subsequent full batch of 2 completes correctly.
